// File: rtl/data_mem_pkg.sv
// Shared definitions for the handshaked data memory controller.
// Contents:
//   state_t            - controller FSM states (CLEAR, IDLE, WAIT)
//   LAT_MIN / LAT_MAX  - legal range of the read-latency parameter
//   lat_ok()           - elaboration-time check of a latency value
package data_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    function automatic bit lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/data_mem_core.sv
// Storage array for the data memory controller: W bits x 2**A words.
// One synchronous write port and one combinational read port, no control
// logic and no reset (contents survive reset; only the controller's clear
// sequence zeroes them).
// Ports:
//   clk   in  1 : write clock
//   we    in  1 : write enable
//   waddr in  A : write address
//   wdata in  W : write data
//   raddr in  A : read address
//   rdata out W : read data (combinational from raddr)
module data_mem_core #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [A-1:0] raddr,
    output logic [W-1:0] rdata
);

    localparam int DEPTH = 2 ** A;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked data memory controller. Wraps a 2**A x W storage array behind a
// REQ/READY interface with a registered read latency of LAT cycles (1..4),
// single-cycle writes and an optional zero-fill sequence after reset.
// Ports:
//   CLK     in  1 : clock, all state changes on the rising edge
//   RESET_N in  1 : asynchronous active-low reset
//   REQ     in  1 : access request, sampled only while READY=1
//   WE      in  1 : 1 = write, 0 = read (qualified by REQ)
//   ADDR    in  A : word address
//   DIN     in  W : write data
//   READY   out 1 : a request is accepted this cycle
//   BUSY    out 1 : clear sequence in progress
//   RVALID  out 1 : one-cycle pulse marking valid read data on DOUT
//   DOUT    out W : read data, forced to 0 whenever RVALID=0
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int W              = 8,
    parameter int A              = 8,
    parameter int LAT            = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         REQ,
    input  logic         WE,
    input  logic [A-1:0] ADDR,
    input  logic [W-1:0] DIN,
    output logic         READY,
    output logic         BUSY,
    output logic         RVALID,
    output logic [W-1:0] DOUT
);

    if (!lat_ok(LAT)) begin : g_bad_lat
        $fatal(1, "data_mem_ctrl: LAT must lie in 1..4");
    end
    if ((W < 1) || (W > 64)) begin : g_bad_width
        $fatal(1, "data_mem_ctrl: W must lie in 1..64");
    end

    localparam state_t       RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [A-1:0] LAST_ADDR   = '1;
    // The wait counter counts down to 0 and the data is loaded on the edge
    // where it reads 0, so a LAT-cycle read spends LAT-1 edges in WAIT.
    localparam logic [1:0]   WAIT_LOAD   = (LAT >= 2) ? 2'(LAT - 2) : 2'd0;

    state_t       state_reg,    state_next;
    logic [A-1:0] clr_cnt_reg,  clr_cnt_next;
    logic [1:0]   wait_cnt_reg, wait_cnt_next;
    logic [A-1:0] addr_reg,     addr_next;
    logic         rvalid_reg,   rvalid_next;
    logic [W-1:0] dout_reg,     dout_next;

    logic         mem_we;
    logic [A-1:0] mem_waddr;
    logic [W-1:0] mem_wdata;
    logic [A-1:0] mem_raddr;
    logic [W-1:0] mem_rdata;

    data_mem_core #(
        .W (W),
        .A (A)
    ) u_core (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= RESET_STATE;
            clr_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            rvalid_reg   <= 1'b0;
            dout_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            rvalid_reg   <= rvalid_next;
            dout_reg     <= dout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        rvalid_next   = 1'b0;
        dout_next     = '0;
        mem_we        = 1'b0;
        mem_waddr     = ADDR;
        mem_wdata     = DIN;
        mem_raddr     = ADDR;

        case (state_reg)
            CLEAR: begin
                // Requests are ignored; the array is zero-filled one word
                // per edge. The counter wraps back to 0 after the last word.
                mem_we       = 1'b1;
                mem_waddr    = clr_cnt_reg;
                mem_wdata    = '0;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (REQ) begin
                    if (WE) begin
                        mem_we = 1'b1;
                    end else if (LAT == 1) begin
                        rvalid_next = 1'b1;
                        dout_next   = mem_rdata;
                    end else begin
                        addr_next     = ADDR;
                        wait_cnt_next = WAIT_LOAD;
                        state_next    = WAIT;
                    end
                end
            end
            WAIT: begin
                // No writes can be accepted here, so reading the array at
                // the end of the wait still returns current data.
                mem_raddr = addr_reg;
                if (wait_cnt_reg == 2'd0) begin
                    rvalid_next = 1'b1;
                    dout_next   = mem_rdata;
                    state_next  = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    assign READY  = (state_reg == IDLE);
    assign BUSY   = (state_reg == CLEAR);
    assign RVALID = rvalid_reg;
    assign DOUT   = dout_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. Two instances share one clock:
//   u_lat1 : W=8, A=6, LAT=1, clear on reset
//   u_lat3 : W=8, A=4, LAT=3, clear on reset
// Read expectations (data plus the cycle RVALID must appear in) go into a
// per-instance scoreboard queue; a single monitor process compares them with
// RVALID/DOUT. Other observations are posted to a check queue drained by the
// same monitor, which owns the pass/fail counters.
module tb_data_mem_ctrl;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] req;
    logic [1:0] we;
    logic [5:0] addr [2];
    logic [7:0] din  [2];
    logic [1:0] ready;
    logic [1:0] busy;
    logic [1:0] rvalid;
    logic [7:0] dout [2];

    int cyc    = 0;
    int n_run  = 0;
    int n_fail = 0;

    exp_t        sb0 [$];
    exp_t        sb1 [$];
    string       tag_q [$];
    logic [63:0] act_q [$];
    logic [63:0] req_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl #(.W(8), .A(6), .LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
        .CLK(clk), .RESET_N(rst_n[0]), .REQ(req[0]), .WE(we[0]),
        .ADDR(addr[0]), .DIN(din[0]), .READY(ready[0]), .BUSY(busy[0]),
        .RVALID(rvalid[0]), .DOUT(dout[0])
    );

    data_mem_ctrl #(.W(8), .A(4), .LAT(3), .CLEAR_ON_RESET(1)) u_lat3 (
        .CLK(clk), .RESET_N(rst_n[1]), .REQ(req[1]), .WE(we[1]),
        .ADDR(addr[1][3:0]), .DIN(din[1]), .READY(ready[1]), .BUSY(busy[1]),
        .RVALID(rvalid[1]), .DOUT(dout[1])
    );

    task automatic post(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tag_q.push_back(tag);
        act_q.push_back(act);
        req_q.push_back(exp);
    endtask

    // Returns at a falling edge with READY=1 on instance k.
    task automatic wait_ready(input int k, input string tag);
        int n = 0;
        @(negedge clk);
        while (ready[k] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ready[k] !== 1'b1) post({tag, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_clear(input int k, input int c0, input int edges);
        int n = 0;
        while (busy[k] !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        post($sformatf("clear_len_u%0d", k), 64'(cyc - c0), 64'(edges));
        post($sformatf("ready_after_clear_u%0d", k), 64'(ready[k]), 64'd1);
    endtask

    task automatic do_write(input int k, input logic [5:0] a, input logic [7:0] d);
        wait_ready(k, "wr");
        req[k] = 1'b1; we[k] = 1'b1; addr[k] = a; din[k] = d;
        @(posedge clk);
        #1;
        req[k] = 1'b0; we[k] = 1'b0;
    endtask

    task automatic do_read(input int k, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        int   lat = (k == 0) ? 1 : 3;
        wait_ready(k, "rd");
        req[k] = 1'b1; we[k] = 1'b0; addr[k] = a;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        e.due  = 32'(cyc + lat - 1);
        e.data = d;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        $display("[TB] u%0d read  addr=%02h expect %02h at cycle %0d", k, a, d, e.due);
    endtask

    // Monitor: sole owner of n_run / n_fail.
    initial begin
        string       t;
        logic [63:0] a, x;
        exp_t        e;
        bit          have;
        forever begin
            @(negedge clk);
            while (tag_q.size() > 0) begin
                t = tag_q.pop_front();
                a = act_q.pop_front();
                x = req_q.pop_front();
                n_run++;
                if (a !== x) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, expected %0h", t, a, x);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (rvalid[k] === 1'b1) begin
                    have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                    n_run++;
                    if (!have) begin
                        n_fail++;
                        $display("FAIL rd_unexpected_u%0d: RVALID=1 DOUT=%02h at cycle %0d, none expected",
                                 k, dout[k], cyc);
                    end else begin
                        if (k == 0) e = sb0.pop_front();
                        else        e = sb1.pop_front();
                        if (dout[k] !== e.data) begin
                            n_fail++;
                            $display("FAIL rd_data_u%0d: got %02h, expected %02h", k, dout[k], e.data);
                        end
                        n_run++;
                        if (cyc != int'(e.due)) begin
                            n_fail++;
                            $display("FAIL rd_cycle_u%0d: RVALID at cycle %0d, expected %0d", k, cyc, e.due);
                        end
                    end
                end else begin
                    n_run++;
                    if (rvalid[k] !== 1'b0 || dout[k] !== 8'h00) begin
                        n_fail++;
                        $display("FAIL idle_out_u%0d: RVALID=%b DOUT=%02h, expected 0/00 at cycle %0d",
                                 k, rvalid[k], dout[k], cyc);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        int c1;
        int t;
        exp_t e;
        rst_n = 2'b00; req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
        repeat (3) @(negedge clk);
        post("reset_busy_ready", 64'({busy, ready}), 64'h0000_0000_0000_000c);
        rst_n = 2'b11;
        c0 = cyc;
        fork
            begin : lat1_seq
                // Write request held while clearing must be ignored.
                req[0] = 1'b1; we[0] = 1'b1; addr[0] = 6'h20; din[0] = 8'h77;
                repeat (60) @(negedge clk);
                req[0] = 1'b0; we[0] = 1'b0;
                wait_clear(0, c0, 64);
                do_read(0, 6'h20, 8'h00);
                do_write(0, 6'h10, 8'hA5);
                do_read(0, 6'h10, 8'hA5);
                do_write(0, 6'h01, 8'h01);
                do_write(0, 6'h02, 8'h02);
                do_write(0, 6'h03, 8'h03);
                do_read(0, 6'h01, 8'h01);
                do_read(0, 6'h02, 8'h02);
                do_read(0, 6'h03, 8'h03);
                do_write(0, 6'h3F, 8'h5C);
                do_read(0, 6'h3F, 8'h5C);
                do_read(0, 6'h00, 8'h00);
            end
            begin : lat3_seq
                wait_clear(1, c0, 16);
                for (int i = 0; i < 16; i++) do_read(1, 6'(i), 8'h00);
                do_write(1, 6'h2, 8'h5A);
                do_write(1, 6'h3, 8'h3C);
                // LAT=3 read accepted at edge t, with a write held during WAIT.
                wait_ready(1, "rd3");
                req[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'h3;
                @(posedge clk);
                #1;
                t = cyc;
                e.due = 32'(t + 2); e.data = 8'h3C;
                sb1.push_back(e);
                $display("[TB] u1 read  addr=03 expect 3c at cycle %0d (write to 02 held during wait)", t + 2);
                we[1] = 1'b1; addr[1] = 6'h2; din[1] = 8'hC3;
                @(negedge clk);
                post("wait_ready_t1", 64'(ready[1]), 64'd0);
                @(negedge clk);
                post("wait_ready_t2", 64'(ready[1]), 64'd0);
                @(negedge clk);
                post("ready_back_t3", 64'(ready[1]), 64'd1);
                req[1] = 1'b0; we[1] = 1'b0;
                do_read(1, 6'h2, 8'h5A);
                // Reset during WAIT: the pending read must never complete.
                do_write(1, 6'h4, 8'h99);
                wait_ready(1, "rd_rst");
                req[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'h4;
                @(posedge clk);
                #1;
                req[1] = 1'b0;
                $display("[TB] u1 read  addr=04 aborted by reset, no response expected");
                @(negedge clk);
                rst_n[1] = 1'b0;
                #1;
                post("rst_mid_wait", 64'({busy[1], ready[1], rvalid[1]}), 64'h4);
                post("rst_mid_wait_dout", 64'(dout[1]), 64'd0);
                repeat (3) @(negedge clk);
                rst_n[1] = 1'b1;
                c1 = cyc;
                wait_clear(1, c1, 16);
                do_read(1, 6'h4, 8'h00);
            end
        join
        repeat (6) @(negedge clk);
        post("scoreboard_drained", 64'(sb0.size() + sb1.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
